sysmanage_responder: RTL
========================

# sysmanage_responder

Slave-side endpoint of the PRV664 system-manage channel. Accepts 8-bit commands over the valid/ready `sysmanage_interface` (slave modport) and executes them. Cache and TLB flushes are sequenced through per-target req/ack handshakes with a timeout, and a halt level is driven to the core. Each command finishes with a one-cycle completion pulse and status. Sits in the core top, between the system-manage master (debug/CSR side) and the cache/MMU flush ports.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1024: maximum cycles a flush request may wait for its ack. Legal range is ≥2.
- `TW`, `$clog2(TIMEOUT_CYCLES)`: timeout counter width.

Ports:
- `clk_i`  in  1  clock. One clock; all logic is on its rising edge.
- `srstn_i`  in  1  reset. Synchronous, active-low.
- `sm_valid`  in  1  command valid (interface `valid`).
- `sm_ready`  out  1  responder can accept (interface `ready`).
- `sm_command`  in  8  command code (interface `command`).
- `dcache_flush_req`  out  1  D-cache flush request.
- `dcache_flush_ack`  in  1  D-cache flush done.
- `icache_flush_req`  out  1  I-cache flush request.
- `icache_flush_ack`  in  1  I-cache flush done.
- `tlb_flush_req`  out  1  TLB flush request.
- `tlb_flush_ack`  in  1  TLB flush done.
- `core_halt_o`  out  1  core halt level.
- `done_o`  out  1  one-cycle completion pulse.
- `err_code_o`  out  2  status, valid only with `done_o`: 0 = OK, 1 = illegal command, 2 = timeout.

## Operation
- Command codes: 0x01 FLUSH_I, 0x02 FLUSH_D, 0x03 FLUSH_ALL, 0x04 FLUSH_TLB, 0x10 HALT, 0x11 RESUME. Any other code is illegal.
- FSM states: IDLE, DFLUSH, IFLUSH, TFLUSH, DONE.
- IDLE:
  - `sm_ready` = 1.
  - Transfer occurs on `sm_valid & sm_ready`; the command is registered into `cmd_q`.
  - FLUSH_D goes to DFLUSH. FLUSH_I goes to IFLUSH. FLUSH_TLB goes to TFLUSH. FLUSH_ALL goes to DFLUSH.
  - HALT sets `core_halt_o`. RESUME clears `core_halt_o`. Both then go to DONE with err 0.
  - An illegal code goes to DONE with err 1; `core_halt_o` is unchanged.
- Flush states:
  - The matching `*_flush_req` is high for every cycle the FSM is in that state. All other requests are 0.
  - A 1 on the matching ack, sampled at a clock edge while in the state, completes the step.
  - FLUSH_ALL runs in fixed order DFLUSH → IFLUSH → TFLUSH → DONE. Single flushes go straight to DONE.
  - Acks from non-matching targets, and any ack while in IDLE or DONE, are ignored.
- Timeout:
  - `tcnt` (TW bits) clears on entry to each flush state and increments every cycle spent in it.
  - If `tcnt == TIMEOUT_CYCLES-1` and the ack is 0, go to DONE with err 2. Remaining FLUSH_ALL steps are skipped.
  - If the ack and the timeout condition coincide, the ack wins.
- DONE: `done_o` = 1 and `err_code_o` = latched status for exactly one cycle. The next state is IDLE. `sm_ready` = 0.
- `core_halt_o` is independent of flushes. Flush commands are accepted while halted.
- HALT while halted, and RESUME while running, complete with err 0 and no level change.

## Timing
- Reset (`srstn_i` = 0 at an edge):
  - State goes to IDLE.
  - `sm_ready` = 1.
  - All `*_flush_req` = 0, `core_halt_o` = 0, `done_o` = 0, `err_code_o` = 0, `tcnt` = 0.
  - Reset mid-flush drops the request in the next cycle and does not emit `done_o`.
- All outputs are registered or decoded from the registered state only. There is no combinational path from any input to any output.
- `sm_ready` = 1 exactly in IDLE. The master holds `sm_valid`/`sm_command` until the transfer. Back-to-back commands are accepted no sooner than the cycle after `done_o`.
- Latency, with the transfer at edge T:
  - HALT, RESUME and illegal commands give `done_o` in cycle T+1. `core_halt_o` changes in cycle T+1.
  - Single flush: the request is high from cycle T+1. If the ack is sampled at edge T+k, the request is 0 and `done_o` = 1 in cycle T+k+1.
  - FLUSH_ALL: the next request rises in the cycle after the previous ack is sampled. There are no idle gaps between steps.
  - Timeout: the request is high for TIMEOUT_CYCLES cycles, then `done_o` with err 2 follows in the next cycle.

## Test plan
- Reset, then HALT (0x10), then RESUME (0x11): `core_halt_o` is 1 from cycle T+1 and `done_o` err 0 in cycle T+1. It returns to 0 after RESUME. `sm_ready` is low only in the DONE cycle.
- FLUSH_D (0x02) with the ack 5 cycles after the request rises: `dcache_flush_req` high for 5 cycles, then `done_o` err 0. The I-cache and TLB requests never assert.
- FLUSH_ALL (0x03) with acks at 2, 3 and 1 cycles: the requests go D → I → TLB, never overlap, and `done_o` err 0 follows the TLB ack. A spurious `icache_flush_ack` during DFLUSH is ignored.
- FLUSH_TLB with no ack and TIMEOUT_CYCLES = 8: `tlb_flush_req` high for 8 cycles, then `done_o` with err 2. A follow-up FLUSH_I is accepted normally.
- Illegal code 0x7F, and ack/timeout coincident on the last cycle: illegal gives err 1 with `core_halt_o` unchanged; the coincident case gives err 0.
- Assert `srstn_i` = 0 during IFLUSH: the next cycle shows the request 0, IDLE, `sm_ready` 1 and no `done_o`. A later command is accepted and completes.

Source files
------------

// File: rtl/sysmanage_responder.sv
// Slave endpoint of the PRV664 system-manage channel: accepts 8-bit commands,
// sequences cache/TLB flush handshakes with a timeout and drives the core halt level.
module sysmanage_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TW             = $clog2(TIMEOUT_CYCLES)
) (
    input  logic       clk_i,
    input  logic       srstn_i,
    input  logic       sm_valid,
    output logic       sm_ready,
    input  logic [7:0] sm_command,
    output logic       dcache_flush_req,
    input  logic       dcache_flush_ack,
    output logic       icache_flush_req,
    input  logic       icache_flush_ack,
    output logic       tlb_flush_req,
    input  logic       tlb_flush_ack,
    output logic       core_halt_o,
    output logic       done_o,
    output logic [1:0] err_code_o
);

    localparam logic [7:0] CMD_FLUSH_I   = 8'h01;
    localparam logic [7:0] CMD_FLUSH_D   = 8'h02;
    localparam logic [7:0] CMD_FLUSH_ALL = 8'h03;
    localparam logic [7:0] CMD_FLUSH_TLB = 8'h04;
    localparam logic [7:0] CMD_HALT      = 8'h10;
    localparam logic [7:0] CMD_RESUME    = 8'h11;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DFLUSH,
        ST_IFLUSH,
        ST_TFLUSH,
        ST_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          ready_q, ready_d;
    logic          dreq_q, dreq_d;
    logic          ireq_q, ireq_d;
    logic          treq_q, treq_d;
    logic          halt_q, halt_d;
    logic          done_q, done_d;
    logic [1:0]    err_q, err_d;
    logic          timeout;
    logic          is_all;

    assign timeout = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign is_all  = (cmd_q == CMD_FLUSH_ALL);

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        halt_d  = halt_q;
        err_d   = ERR_OK;

        case (state_q)
            ST_IDLE: begin
                if (sm_valid && ready_q) begin
                    cmd_d = sm_command;
                    case (sm_command)
                        CMD_FLUSH_D, CMD_FLUSH_ALL: state_d = ST_DFLUSH;
                        CMD_FLUSH_I:                state_d = ST_IFLUSH;
                        CMD_FLUSH_TLB:              state_d = ST_TFLUSH;
                        CMD_HALT: begin
                            halt_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                        CMD_RESUME: begin
                            halt_d  = 1'b0;
                            state_d = ST_DONE;
                        end
                        default: begin
                            err_d   = ERR_ILLEGAL;
                            state_d = ST_DONE;
                        end
                    endcase
                end
            end
            ST_DFLUSH: begin
                if (dcache_flush_ack) begin
                    state_d = is_all ? ST_IFLUSH : ST_DONE;
                end else if (timeout) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_DONE;
                end
            end
            ST_IFLUSH: begin
                if (icache_flush_ack) begin
                    state_d = is_all ? ST_TFLUSH : ST_DONE;
                end else if (timeout) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_DONE;
                end
            end
            ST_TFLUSH: begin
                if (tlb_flush_ack) begin
                    state_d = ST_DONE;
                end else if (timeout) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Counter restarts on every state change, so each flush step gets a fresh budget.
        if ((state_d != state_q) || (state_d == ST_IDLE) || (state_d == ST_DONE)) begin
            tcnt_d = '0;
        end else begin
            tcnt_d = tcnt_q + TW'(1);
        end

        ready_d = (state_d == ST_IDLE);
        dreq_d  = (state_d == ST_DFLUSH);
        ireq_d  = (state_d == ST_IFLUSH);
        treq_d  = (state_d == ST_TFLUSH);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (!srstn_i) begin
            state_q <= ST_IDLE;
            cmd_q   <= 8'h00;
            tcnt_q  <= '0;
            ready_q <= 1'b1;
            dreq_q  <= 1'b0;
            ireq_q  <= 1'b0;
            treq_q  <= 1'b0;
            halt_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            tcnt_q  <= tcnt_d;
            ready_q <= ready_d;
            dreq_q  <= dreq_d;
            ireq_q  <= ireq_d;
            treq_q  <= treq_d;
            halt_q  <= halt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign sm_ready         = ready_q;
    assign dcache_flush_req = dreq_q;
    assign icache_flush_req = ireq_q;
    assign tlb_flush_req    = treq_q;
    assign core_halt_o      = halt_q;
    assign done_o           = done_q;
    assign err_code_o       = err_q;

endmodule
